// File: rtl/mvm_pkg.sv
// Shared types and arithmetic helpers for the matrix-vector MAC core.
package mvm_pkg;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  // Accumulator wide enough that N full-scale products cannot overflow.
  function automatic int acc_w(input int n, input int dw);
    return 2 * dw + $clog2(n);
  endfunction

  function automatic longint sat_max(input int dw);
    return (64'sd1 <<< (dw - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int dw);
    return -(64'sd1 <<< (dw - 1));
  endfunction

endpackage

// File: rtl/matrix_vector_mac_if.sv
// Streaming vector in/out plus coefficient write port of the matrix-vector MAC.
interface matrix_vector_mac_if #(
  parameter int N  = 3,
  parameter int DW = 16
);
  logic [N*DW-1:0]        in_vec_i;
  logic                   in_valid_i;
  logic                   in_ready_o;
  logic [N*DW-1:0]        out_vec_o;
  logic [N-1:0]           out_sat_o;
  logic                   out_valid_o;
  logic                   out_ready_i;
  logic                   coef_we_i;
  logic [$clog2(N*N)-1:0] coef_addr_i;
  logic [DW-1:0]          coef_data_i;
  logic                   coef_commit_i;
  logic                   busy_o;

  modport slave (
    input  in_vec_i, in_valid_i, out_ready_i,
    input  coef_we_i, coef_addr_i, coef_data_i, coef_commit_i,
    output in_ready_o, out_vec_o, out_sat_o, out_valid_o, busy_o
  );

  modport master (
    output in_vec_i, in_valid_i, out_ready_i,
    output coef_we_i, coef_addr_i, coef_data_i, coef_commit_i,
    input  in_ready_o, out_vec_o, out_sat_o, out_valid_o, busy_o
  );
endinterface

// File: rtl/mvm_shift_sat.sv
// Per-row result stage: arithmetic right shift (floor) then clip to DW bits.
module mvm_shift_sat
  import mvm_pkg::*;
#(
  parameter int ACC_W = 34,
  parameter int DW    = 16,
  parameter int SHIFT = 0
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic        [DW-1:0]    y,
  output logic                    sat
);
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(sat_max(DW));
  localparam logic signed [ACC_W-1:0] MINV = ACC_W'(sat_min(DW));

  logic signed [ACC_W-1:0] sh;

  assign sh = acc >>> SHIFT;

  always_comb begin
    sat = 1'b1;
    y   = MAXV[DW-1:0];
    if (sh > MAXV) begin
      y = MAXV[DW-1:0];
    end else if (sh < MINV) begin
      y = MINV[DW-1:0];
    end else begin
      sat = 1'b0;
      y   = sh[DW-1:0];
    end
  end
endmodule

// File: rtl/matrix_vector_mac.sv
// N x N signed matrix-vector multiply, one column per cycle, with a
// double-buffered coefficient bank and shift+saturate output stage.
module matrix_vector_mac
  import mvm_pkg::*;
#(
  parameter int N     = 3,
  parameter int DW    = 16,
  parameter int SHIFT = 0
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  matrix_vector_mac_if.slave bus
);
  localparam int ACC_W = acc_w(N, DW);
  localparam int NN    = N * N;
  localparam int KW    = $clog2(N + 1);

  state_t                state;
  logic [KW-1:0]         k, kk;
  logic [N-1:0][DW-1:0]  x_q;
  logic [NN-1:0][DW-1:0] shadow, shadow_nxt, active;
  logic                  pending;
  logic [N-1:0][DW-1:0]  y_w, out_vec;
  logic [N-1:0]          sat_w, out_sat;
  logic                  out_valid, busy;
  logic                  in_ready, accept, acc_en;

  assign in_ready = !pending && (state == IDLE || (state == OUT && bus.out_ready_i));
  assign accept   = bus.in_valid_i && in_ready;
  // k == N is the extra cycle that registers the shifted/saturated result,
  // keeping multiply-add and shift-saturate in separate cycles.
  assign acc_en   = (state == MAC) && (k != KW'(N));
  assign kk       = acc_en ? k : '0;

  // Same-cycle write is visible to a copy happening in that cycle.
  always_comb begin
    shadow_nxt = shadow;
    if (bus.coef_we_i && int'(bus.coef_addr_i) < NN)
      shadow_nxt[bus.coef_addr_i] = bus.coef_data_i;
  end

  for (genvar r = 0; r < N; r++) begin : g_row
    logic signed [DW-1:0]    a_w, x_w;
    logic signed [2*DW-1:0]  prod;
    logic signed [ACC_W-1:0] acc;

    assign a_w  = active[r*N + int'(kk)];
    assign x_w  = x_q[kk];
    assign prod = (2*DW)'(a_w) * (2*DW)'(x_w);

    always_ff @(posedge clk_i) begin
      if (!rstn_i || accept) acc <= '0;
      else if (acc_en)       acc <= acc + ACC_W'(prod);
    end

    mvm_shift_sat #(.ACC_W(ACC_W), .DW(DW), .SHIFT(SHIFT)) u_sat (
      .acc (acc),
      .y   (y_w[r]),
      .sat (sat_w[r])
    );
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state     <= IDLE;
      k         <= '0;
      x_q       <= '0;
      shadow    <= '0;
      active    <= '0;
      pending   <= 1'b0;
      out_vec   <= '0;
      out_sat   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      shadow <= shadow_nxt;
      if (bus.coef_commit_i) pending <= 1'b1;
      case (state)
        IDLE: begin
          if (pending) begin
            active  <= shadow_nxt;
            pending <= 1'b0;
          end else if (accept) begin
            x_q   <= bus.in_vec_i;
            k     <= '0;
            state <= MAC;
            busy  <= 1'b1;
          end
        end
        MAC: begin
          if (k == KW'(N)) begin
            out_vec   <= y_w;
            out_sat   <= sat_w;
            out_valid <= 1'b1;
            state     <= OUT;
          end else begin
            k <= k + 1'b1;
          end
        end
        OUT: begin
          if (bus.out_ready_i) begin
            out_valid <= 1'b0;
            if (accept) begin
              x_q   <= bus.in_vec_i;
              k     <= '0;
              state <= MAC;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_vec_o   = out_vec;
  assign bus.out_sat_o   = out_sat;
  assign bus.out_valid_o = out_valid;
  assign bus.busy_o      = busy;
endmodule

// File: tb/tb_matrix_vector_mac.sv
// Bench for matrix_vector_mac: SHIFT=0 and SHIFT=15 instances, vector table,
// scoreboard with latency tracking, plus stall/commit/reset sequences.
module tb_matrix_vector_mac;
  localparam int N  = 3;
  localparam int DW = 16;

  typedef logic [N-1:0][DW-1:0]   vec_t;
  typedef logic [N*N-1:0][DW-1:0] mat_t;
  typedef struct { bit sel; mat_t a; vec_t x; vec_t y; logic [N-1:0] sat; } rec_t;
  typedef struct { vec_t y; logic [N-1:0] sat; } res_t;
  typedef struct packed { logic rdy; logic vld; logic busy; logic ordy; vec_t y; logic [N-1:0] sat; } out_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  res_t exp_q0[$], exp_q1[$];
  int   acc_q0[$], acc_q1[$];
  bit   pv[2];
  rec_t tbl[8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  matrix_vector_mac_if #(.N(N), .DW(DW)) bus0 ();
  matrix_vector_mac_if #(.N(N), .DW(DW)) bus1 ();

  matrix_vector_mac #(.N(N), .DW(DW), .SHIFT(0))  dut0 (.clk_i(clk), .rstn_i(rstn), .bus(bus0));
  matrix_vector_mac #(.N(N), .DW(DW), .SHIFT(15)) dut1 (.clk_i(clk), .rstn_i(rstn), .bus(bus1));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t v3(input int a, input int b, input int c);
    vec_t v;
    v[0] = 16'(a); v[1] = 16'(b); v[2] = 16'(c);
    return v;
  endfunction

  function automatic mat_t m9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    mat_t m;
    m[0] = 16'(a0); m[1] = 16'(a1); m[2] = 16'(a2);
    m[3] = 16'(a3); m[4] = 16'(a4); m[5] = 16'(a5);
    m[6] = 16'(a6); m[7] = 16'(a7); m[8] = 16'(a8);
    return m;
  endfunction

  function automatic rec_t mk(input bit s, input mat_t a, input vec_t x, input vec_t y, input logic [N-1:0] sat);
    rec_t r;
    r.sel = s; r.a = a; r.x = x; r.y = y; r.sat = sat;
    return r;
  endfunction

  // Integer reference: exact sum, floor shift, clip.
  function automatic res_t model(input mat_t a, input vec_t x, input int sh);
    res_t   r;
    longint acc, v;
    for (int i = 0; i < N; i++) begin
      acc = 0;
      for (int j = 0; j < N; j++)
        acc += longint'($signed(a[i*N+j])) * longint'($signed(x[j]));
      v = acc >>> sh;
      r.sat[i] = (v > 32767) || (v < -32768);
      if (v > 32767) v = 32767;
      else if (v < -32768) v = -32768;
      r.y[i] = v[15:0];
    end
    return r;
  endfunction

  function automatic out_t get(input bit s);
    out_t o;
    if (s) begin
      o.rdy = bus1.in_ready_o; o.vld = bus1.out_valid_o; o.busy = bus1.busy_o;
      o.ordy = bus1.out_ready_i; o.y = bus1.out_vec_o; o.sat = bus1.out_sat_o;
    end else begin
      o.rdy = bus0.in_ready_o; o.vld = bus0.out_valid_o; o.busy = bus0.busy_o;
      o.ordy = bus0.out_ready_i; o.y = bus0.out_vec_o; o.sat = bus0.out_sat_o;
    end
    return o;
  endfunction

  task automatic set_in(input bit s, input logic v, input vec_t x);
    if (s) begin bus1.in_valid_i = v; bus1.in_vec_i = x; end
    else   begin bus0.in_valid_i = v; bus0.in_vec_i = x; end
  endtask

  task automatic set_coef(input bit s, input logic we, input int addr, input logic [DW-1:0] d, input logic cm);
    if (s) begin
      bus1.coef_we_i = we; bus1.coef_addr_i = 4'(addr); bus1.coef_data_i = d; bus1.coef_commit_i = cm;
    end else begin
      bus0.coef_we_i = we; bus0.coef_addr_i = 4'(addr); bus0.coef_data_i = d; bus0.coef_commit_i = cm;
    end
  endtask

  task automatic push_exp(input bit s, input res_t r);
    if (s) exp_q1.push_back(r);
    else   exp_q0.push_back(r);
  endtask

  // Writes all coefficients; commit (optional) rides on the last write.
  task automatic load(input bit s, input mat_t a, input bit commit);
    for (int i = 0; i < N*N; i++) begin
      @(posedge clk); #1;
      set_coef(s, 1'b1, i, a[i], commit && (i == N*N-1));
    end
    @(posedge clk); #1;
    set_coef(s, 1'b0, 0, '0, 1'b0);
  endtask

  task automatic send(input bit s, input vec_t x);
    int n = 0;
    set_in(s, 1'b1, x);
    @(negedge clk);
    while (!get(s).rdy && n < 40) begin @(negedge clk); n++; end
    chk("accept_timeout", get(s).rdy, 1);
    @(posedge clk); #1;
    if (s) acc_q1.push_back(cyc);
    else   acc_q0.push_back(cyc);
    set_in(s, 1'b0, '0);
  endtask

  task automatic drain(input bit s);
    int n = 0;
    while ((s ? exp_q1.size() : exp_q0.size()) != 0 && n < 60) begin @(negedge clk); n++; end
    chk("drain_timeout", s ? exp_q1.size() : exp_q0.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(input bit s);
    int n = 0;
    @(negedge clk);
    while (!get(s).vld && n < 40) begin @(negedge clk); n++; end
    chk("valid_timeout", get(s).vld, 1);
  endtask

  task automatic chk_idle(input bit s, input string tag);
    out_t o = get(s);
    chk({tag, "_in_ready"},  o.rdy,  1);
    chk({tag, "_out_valid"}, o.vld,  0);
    chk({tag, "_busy"},      o.busy, 0);
    chk({tag, "_out_vec"},   o.y,    0);
    chk({tag, "_out_sat"},   o.sat,  0);
  endtask

  task automatic mon(input bit s);
    out_t o;
    res_t e;
    int   t;
    o = get(s);
    if (!rstn) begin pv[s] = 1'b0; return; end
    if (o.vld && !pv[s]) begin
      if ((s ? acc_q1.size() : acc_q0.size()) == 0) begin
        checks++; errors++;
        $display("FAIL latency_%0d: out_valid rose with no accepted vector", s);
      end else begin
        t = s ? acc_q1.pop_front() : acc_q0.pop_front();
        chk($sformatf("latency_%0d", s), cyc - t, N + 1);
      end
    end
    pv[s] = o.vld;
    if (o.vld && o.ordy) begin
      if ((s ? exp_q1.size() : exp_q0.size()) == 0) begin
        checks++; errors++;
        $display("FAIL result_%0d: unexpected output 0x%0h, expected none", s, o.y);
      end else begin
        e = s ? exp_q1.pop_front() : exp_q0.pop_front();
        chk($sformatf("out_vec_%0d", s), o.y,   e.y);
        chk($sformatf("out_sat_%0d", s), o.sat, e.sat);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(1'b0);
    mon(1'b1);
  end

  initial begin
    res_t r;
    mat_t ma, mb;
    vec_t rx;
    bit   s;

    set_in(1'b0, 1'b0, '0); set_in(1'b1, 1'b0, '0);
    set_coef(1'b0, 1'b0, 0, '0, 1'b0); set_coef(1'b1, 1'b0, 0, '0, 1'b0);
    bus0.out_ready_i = 1'b1; bus1.out_ready_i = 1'b1;

    tbl[0] = mk(0, m9(1,0,0, 0,1,0, 0,0,1), v3(1,-2,3), v3(1,-2,3), 3'b000);
    tbl[1] = mk(0, m9(32767,32767,32767, 32767,32767,32767, 32767,32767,32767),
                v3(32767,32767,32767), v3(32767,32767,32767), 3'b111);
    tbl[2] = mk(0, m9(-32768,-32768,-32768, -32768,-32768,-32768, -32768,-32768,-32768),
                v3(32767,32767,32767), v3(-32768,-32768,-32768), 3'b111);
    tbl[3] = mk(1, m9(16384,0,0, 0,16384,0, 0,0,16384), v3(32767,-32768,2), v3(16383,-16384,1), 3'b000);
    tbl[4] = mk(0, m9(1,2,3, 4,5,6, 7,8,9), v3(1,1,1), v3(6,15,24), 3'b000);
    tbl[5] = mk(0, m9(100,-200,0, 0,0,0, 1,1,1), v3(-300,50,7), v3(-32768,0,-243), 3'b001);
    tbl[6] = mk(0, m9(16383,16384,0, 16384,16384,0, -16384,-16384,0), v3(1,1,0),
                v3(32767,32767,-32768), 3'b010);
    tbl[7] = mk(1, m9(1,0,0, 0,1,0, 0,0,1), v3(-1,1,-32768), v3(-1,0,-1), 3'b000);

    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk_idle(1'b0, "reset0");
    chk_idle(1'b1, "reset1");
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      load(tbl[i].sel, tbl[i].a, 1'b1);
      r.y = tbl[i].y; r.sat = tbl[i].sat;
      push_exp(tbl[i].sel, r);
      send(tbl[i].sel, tbl[i].x);
      drain(tbl[i].sel);
    end

    for (int i = 0; i < 4; i++) begin
      s = i[0];
      for (int j = 0; j < N*N; j++) ma[j] = 16'($urandom_range(0, 65535));
      for (int j = 0; j < N; j++)   rx[j] = 16'($urandom_range(0, 2047)) - 16'd1024;
      load(s, ma, 1'b1);
      push_exp(s, model(ma, rx, s ? 15 : 0));
      send(s, rx);
      drain(s);
    end

    // Output stall with a pending input, then back-to-back accept on release.
    mb = m9(1,2,3, 4,5,6, 7,8,9);
    load(1'b0, mb, 1'b1);
    bus0.out_ready_i = 1'b0;
    r.y = v3(6,15,24); r.sat = '0; push_exp(1'b0, r);
    send(1'b0, v3(1,1,1));
    r.y = v3(-2,-2,-2); r.sat = '0; push_exp(1'b0, r);
    set_in(1'b0, 1'b1, v3(1,0,-1));
    wait_valid(1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_out_vec",  get(1'b0).y,   v3(6,15,24));
      chk("stall_in_ready", get(1'b0).rdy, 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus0.out_ready_i = 1'b1;
    @(negedge clk);
    chk("release_in_ready", get(1'b0).rdy, 1);
    @(posedge clk); #1;
    acc_q0.push_back(cyc);
    set_in(1'b0, 1'b0, '0);
    drain(1'b0);

    // Commit during MAC: in-flight vector keeps the old bank.
    load(1'b0, m9(1,0,0, 0,1,0, 0,0,1), 1'b0);
    r.y = v3(20,47,74); r.sat = '0; push_exp(1'b0, r);
    send(1'b0, v3(2,3,4));
    set_coef(1'b0, 1'b0, 0, '0, 1'b1);
    @(posedge clk); #1;
    set_coef(1'b0, 1'b0, 0, '0, 1'b0);
    wait_valid(1'b0);
    @(negedge clk);
    chk("commit_gap_in_ready", get(1'b0).rdy,  0);
    chk("commit_gap_busy",     get(1'b0).busy, 0);
    @(negedge clk);
    chk("commit_done_in_ready", get(1'b0).rdy, 1);
    @(posedge clk); #1;
    r.y = v3(2,3,4); r.sat = '0; push_exp(1'b0, r);
    send(1'b0, v3(2,3,4));
    drain(1'b0);

    // Reset while k=1: vector discarded, no output afterwards.
    send(1'b0, v3(5,5,5));
    @(posedge clk); #1 rstn = 1'b0;
    @(posedge clk); #1 rstn = 1'b1;
    acc_q0.delete(); acc_q1.delete();
    @(negedge clk);
    chk_idle(1'b0, "rst_mid");
    for (int i = 0; i < N + 3; i++) begin
      @(negedge clk);
      chk("rst_mid_no_valid", get(1'b0).vld, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end
endmodule
